sha512_stream: RTL and testbench
================================

SHA512_STREAM -- requirements
Module: sha512_stream

Interface
REQ-001 Parameter IN_W, default 512, SHALL set the input word width in bits; legal values are 256, 512 and 1024.
REQ-002 Parameter MODE, default 2'd3, SHALL be driven unchanged onto the mode input of the embedded sha512_core (3 = SHA-512).
REQ-003 Parameter CNT_W, default 32, SHALL set the width of the block and message counters.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_data  in  IN_W  message word.
REQ-007 in_valid  in  1  in_data/in_last are valid.
REQ-008 in_last  in  1  this word is the last word of the message.
REQ-009 in_ready  out  1  block accepts a word this cycle.
REQ-010 digest  out  512  final message digest, held stable while digest_valid=1.
REQ-011 digest_valid  out  1  digest available.
REQ-012 digest_ready  in  1  consumer accepts the digest.
REQ-013 busy  out  1  core computing, or the fill buffer is non-empty.
REQ-014 blk_count  out  CNT_W  1024-bit blocks issued to the core since reset; wraps.
REQ-015 msg_count  out  CNT_W  digests delivered since reset; wraps.

Function
REQ-016 Words per block: WPB = 1024/IN_W; a word transfers on a cycle with in_valid=1 and in_ready=1.
REQ-017 Word k of a block (k = 0..WPB-1) SHALL be written to fill-buffer bits [k*IN_W +: IN_W].
REQ-018 in_ready SHALL equal "fill buffer not full".
REQ-019 The buffer SHALL become full on transfer of word WPB-1, or on any transfer with in_last=1.
REQ-020 On an in_last transfer at k<WPB-1, words k+1..WPB-1 SHALL be zero-filled; message padding remains the host's job.
REQ-021 A per-block flag SHALL record whether the block ended with in_last.
REQ-022 Issue SHALL take place when all of the following hold: buffer full, core ready=1, no issue in flight, and digest_valid=0.
REQ-023 On issue, the buffer SHALL be copied into a core-side block register, the block SHALL be marked empty, and exactly one of init/next SHALL pulse for one cycle.
REQ-024 The fill buffer SHALL accept the next block's words while the core computes (double buffering).
REQ-025 The first block after reset, or the first block after a last block, SHALL use init; every other block SHALL use next.
REQ-026 blk_count SHALL increment by 1 per issue.
REQ-027 Core-side FSM states and transitions:
- IDLE -> ISSUE: issue condition of REQ-022 true.
- ISSUE (1 cycle) -> WAIT.
- WAIT: wait one cycle, then wait for core ready=1; go to DONE.
- DONE, non-last block -> IDLE.
- DONE, last block -> OUT: load the digest register and set digest_valid.
REQ-028 In OUT, digest_valid and digest SHALL hold until digest_valid and digest_ready are both 1 in the same cycle.
REQ-029 On that handshake cycle, msg_count SHALL increment, the FSM SHALL return to IDLE, and digest_valid SHALL fall on the next cycle.
REQ-030 A full buffer arriving during OUT SHALL wait; in_ready stays 0 until the buffer is drained.
REQ-031 Latency from last-word transfer to digest_valid = 1 (register) + 1 (ISSUE) + core compute + 1 (DONE) cycles, when the core is idle.
REQ-032 Throughput: the next block's words SHALL never be refused solely because the core is computing, provided the fill buffer is empty.

Reset
REQ-033 While reset_n=0, all of the following SHALL hold: FSM=IDLE, fill buffer empty, word index=0, init=next=0, digest=0, digest_valid=0, blk_count=0, msg_count=0, busy=0, in_ready=1.
REQ-034 Any partial block or pending digest SHALL be discarded, and the core SHALL be reset via reset_n.
REQ-035 After reset, the first block SHALL use init.

Verification
REQ-036 IN_W=512: "abc" padded block as 2 words, in_last on word 1, digest_ready=1 -> one digest = ddaf35a193617aba...a54ca49f, msg_count=1, blk_count=1.
REQ-037 IN_W=256: 896-bit two-block NIST message as 8 words, in_last on word 7 -> init then next, one digest only, blk_count=2.
REQ-038 in_last on word 0 with IN_W=256 -> words 1..3 zero, block issued, digest_valid asserted.
REQ-039 digest_ready=0 for 50 cycles with a second message streaming -> digest stable, in_ready=0 once the buffer is full, second message starts with init after the handshake.
REQ-040 reset_n pulsed low mid-compute -> all outputs at reset values; next message digest correct.
REQ-041 Back-to-back 3-block message with in_valid always 1 -> in_ready never 0 while the buffer is empty; blk_count=3.

Source files
------------

// File: rtl/sha512_stream.sv
// Streaming front end for an iterative SHA-512 block core. It packs IN_W-bit words into
// 1024-bit blocks, double-buffers them against the core and delivers one digest per message.

module sha512_core (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          init,
  input  logic          next,
  input  logic [1:0]    mode,
  input  logic [1023:0] block,
  output logic          ready,
  output logic [511:0]  digest
);
  // Message word t of the block sits at block[t*64 +: 64]; the digest is {H0, ..., H7}.
  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
  localparam logic [63:0] IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [63:0] IV384 [8] = '{
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };

  logic [63:0] h [8];
  logic [63:0] v [8];
  logic [63:0] w [16];
  logic [63:0] iv [8];
  logic [6:0]  round;
  logic        running;
  logic [63:0] t1, t2, w_new;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Mode 2 selects the SHA-384 initial hash; every other mode runs plain SHA-512.
  always_comb begin
    for (int i = 0; i < 8; i++) iv[i] = (mode == 2'd2) ? IV384[i] : IV512[i];
  end

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    t1 = v[7] + (rotr(v[4], 14) ^ rotr(v[4], 18) ^ rotr(v[4], 41))
       + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round] + w[0];
    t2 = (rotr(v[0], 28) ^ rotr(v[0], 34) ^ rotr(v[0], 39))
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 19) ^ rotr(w[14], 61) ^ (w[14] >> 6)) + w[9]
          + (rotr(w[1], 1) ^ rotr(w[1], 8) ^ (w[1] >> 7)) + w[0];
  end

  // One round per cycle; after round 79 the working variables fold into H.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      round   <= '0;
      for (int i = 0; i < 8; i++) begin
        h[i] <= '0;
        v[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (!running) begin
      if (init || next) begin
        for (int i = 0; i < 16; i++) w[i] <= block[i*64 +: 64];
        for (int i = 0; i < 8; i++) begin
          v[i] <= init ? iv[i] : h[i];
          if (init) h[i] <= iv[i];
        end
        round   <= '0;
        running <= 1'b1;
      end
    end else if (round == 7'd80) begin
      for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
      running <= 1'b0;
    end else begin
      v[0] <= t1 + t2;
      v[1] <= v[0];
      v[2] <= v[1];
      v[3] <= v[2];
      v[4] <= v[3] + t1;
      v[5] <= v[4];
      v[6] <= v[5];
      v[7] <= v[6];
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
      round <= round + 7'd1;
    end
  end

  assign ready  = !running;
  assign digest = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
endmodule

module sha512_stream #(
  parameter int         IN_W  = 512,
  parameter logic [1:0] MODE  = 2'd3,
  parameter int         CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [511:0]     digest,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic [CNT_W-1:0] msg_count
);
  localparam int WPB   = 1024 / IN_W;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, OUT} state_t;

  state_t           state, state_nxt;
  logic [1023:0]    fill_data, core_block;
  logic [IDX_W-1:0] word_idx;
  logic             fill_full, fill_last;
  logic             xfer, issue;
  logic             wait_armed, blk_init, blk_last, first_pending;
  logic             core_init, core_next, core_ready;
  logic [511:0]     core_digest;

  assign in_ready     = !fill_full;
  assign xfer         = in_valid && in_ready;
  assign digest_valid = (state == OUT);
  assign core_init    = (state == ISSUE) && blk_init;
  assign core_next    = (state == ISSUE) && !blk_init;
  assign busy         = (state == ISSUE) || (state == WAIT) || (state == DONE)
                      || fill_full || (word_idx != '0);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (fill_full && core_ready && !digest_valid) begin
               issue     = 1'b1;
               state_nxt = ISSUE;
             end
      ISSUE: state_nxt = WAIT;
      // The first WAIT cycle is skipped so the core's ready has time to drop.
      WAIT:  if (wait_armed && core_ready) state_nxt = DONE;
      DONE:  state_nxt = blk_last ? OUT : IDLE;
      OUT:   if (digest_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx  <= '0;
      fill_full <= 1'b0;
      fill_last <= 1'b0;
    end else if (issue) begin
      fill_full <= 1'b0;
    end else if (xfer) begin
      if (in_last || word_idx == LAST_IDX) begin
        fill_full <= 1'b1;
        fill_last <= in_last;
        word_idx  <= '0;
      end else begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  // NOTE: the block buffers carry no reset; they are only read behind fill_full and
  // the FSM, which are reset, so resetting 2 kbit of data would buy nothing.
  always_ff @(posedge clk) begin
    if (xfer) begin
      for (int k = 0; k < WPB; k++) begin
        if (k == int'(word_idx))                 fill_data[k*IN_W +: IN_W] <= in_data;
        else if (in_last && k > int'(word_idx))  fill_data[k*IN_W +: IN_W] <= '0;
      end
    end
    if (issue) core_block <= fill_data;
  end

  // A block uses init when it is the first since reset or follows a last block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_armed    <= 1'b0;
      blk_init      <= 1'b0;
      blk_last      <= 1'b0;
      first_pending <= 1'b1;
      digest        <= '0;
      blk_count     <= '0;
      msg_count     <= '0;
    end else begin
      wait_armed <= (state == WAIT);
      if (issue) begin
        blk_init      <= first_pending;
        blk_last      <= fill_last;
        first_pending <= fill_last;
        blk_count     <= blk_count + 1'b1;
      end
      if (state == DONE && blk_last) digest <= core_digest;
      if (state == OUT && digest_ready) msg_count <= msg_count + 1'b1;
    end
  end

  sha512_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (core_init),
    .next    (core_next),
    .mode    (MODE),
    .block   (core_block),
    .ready   (core_ready),
    .digest  (core_digest)
  );
endmodule

// File: tb/tb_sha512_stream.sv
// Directed bench for sha512_stream: one 512-bit-word instance and one 256-bit-word
// instance, checked against published SHA-512 digests.

module tb_sha512_stream;
  localparam logic [511:0] DIG_ABC = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [511:0] DIG_TWO = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;
  localparam logic [511:0] DIG_EMPTY = 512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e;
  // Last-word transfer to digest_valid: 1 register + 1 issue + 82 core cycles + 1 done.
  localparam int LATENCY = 85;
  localparam int BOUND   = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [511:0] a_data, a_digest;
  logic         a_valid, a_last, a_ready, a_dv, a_dr, a_busy;
  logic [31:0]  a_blk, a_msg;
  logic [255:0] b_data;
  logic [511:0] b_digest;
  logic         b_valid, b_last, b_ready, b_dv, b_dr, b_busy;
  logic [31:0]  b_blk, b_msg;

  int checks = 0;
  int errors = 0;
  logic [63:0]   msg_w [16];
  logic [1023:0] flat;

  sha512_stream #(.IN_W(512)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .in_ready(a_ready), .digest(a_digest), .digest_valid(a_dv), .digest_ready(a_dr),
    .busy(a_busy), .blk_count(a_blk), .msg_count(a_msg)
  );

  sha512_stream #(.IN_W(256)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_ready), .digest(b_digest), .digest_valid(b_dv), .digest_ready(b_dr),
    .busy(b_busy), .blk_count(b_blk), .msg_count(b_msg)
  );

  task automatic pack();
    for (int i = 0; i < 16; i++) flat[i*64 +: 64] = msg_w[i];
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg_w[i] = '0;
    msg_w[0]  = 64'h6162638000000000;
    msg_w[15] = 64'd24;
    pack();
  endtask

  // 896-bit NIST message "abcdefghbcdefghi...nopqrstu": part 0 or part 1 of its padding.
  task automatic load_two(input int part);
    logic [63:0] wv;
    for (int i = 0; i < 16; i++) msg_w[i] = '0;
    if (part == 0) begin
      for (int i = 0; i < 14; i++) begin
        wv = '0;
        for (int b = 0; b < 8; b++) wv = {wv[55:0], 8'(97 + i + b)};
        msg_w[i] = wv;
      end
      msg_w[14] = 64'h8000000000000000;
    end else begin
      msg_w[15] = 64'd896;
    end
    pack();
  endtask

  // Presents one word on instance a (sel=0) or b (sel=1) and returns once it transferred.
  task automatic send_word(input bit sel, input logic [511:0] d, input logic last, output int waited);
    if (sel) begin b_data = d[255:0]; b_last = last; b_valid = 1'b1; end
    else     begin a_data = d;        a_last = last; a_valid = 1'b1; end
    waited = 0;
    while (!(sel ? b_ready : a_ready) && waited < BOUND) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if ((sel ? b_ready : a_ready) !== 1'b1) begin
      errors++;
      $display("FAIL send_word_timeout: in_ready=%b after %0d cycles, required 1", sel ? b_ready : a_ready, waited);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_dv(input bit sel, output int cyc);
    cyc = 0;
    while (!(sel ? b_dv : a_dv) && cyc < BOUND) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if ((sel ? b_dv : a_dv) !== 1'b1) begin
      errors++;
      $display("FAIL digest_timeout: digest_valid=%b after %0d cycles, required 1", sel ? b_dv : a_dv, cyc);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_valid = 0; a_last = 0; a_data = '0; a_dr = 0;
    b_valid = 0; b_last = 0; b_data = '0; b_dr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_ready, a_dv, a_busy, b_ready, b_dv, b_busy} !== 6'b100_100) begin
      errors++;
      $display("FAIL reset_flags: ready/dv/busy a=%b%b%b b=%b%b%b, required 100 100", a_ready, a_dv, a_busy, b_ready, b_dv, b_busy);
    end
    checks++;
    if (a_blk !== 0 || a_msg !== 0 || b_blk !== 0 || b_msg !== 0) begin
      errors++;
      $display("FAIL reset_counts: a=%0d/%0d b=%0d/%0d, required all 0", a_blk, a_msg, b_blk, b_msg);
    end
    checks++;
    if (a_digest !== '0 || b_digest !== '0) begin
      errors++;
      $display("FAIL reset_digest: a=%h b=%h, required 0", a_digest, b_digest);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_abc_512();
    int w0, w1, cyc;
    a_dr = 1'b1;
    load_abc();
    send_word(0, flat[511:0], 1'b0, w0);
    send_word(0, flat[1023:512], 1'b1, w1);
    a_valid = 1'b0;
    wait_dv(0, cyc);
    checks++;
    if (a_digest !== DIG_ABC) begin
      errors++;
      $display("FAIL abc_digest: got %h, required %h", a_digest, DIG_ABC);
    end
    checks++;
    if (cyc != LATENCY) begin
      errors++;
      $display("FAIL abc_latency: got %0d cycles, required %0d", cyc, LATENCY);
    end
    @(posedge clk); #1;
    checks++;
    if (a_dv !== 1'b0 || a_msg !== 32'd1 || a_blk !== 32'd1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL abc_after: dv=%b msg=%0d blk=%0d busy=%b, required 0 1 1 0", a_dv, a_msg, a_blk, a_busy);
    end
  endtask

  task automatic test_two_block_256();
    int wt, cyc;
    b_dr = 1'b1;
    load_two(0);
    for (int k = 0; k < 4; k++) send_word(1, {256'b0, flat[k*256 +: 256]}, 1'b0, wt);
    load_two(1);
    for (int k = 0; k < 4; k++) send_word(1, {256'b0, flat[k*256 +: 256]}, k == 3, wt);
    b_valid = 1'b0;
    wait_dv(1, cyc);
    checks++;
    if (b_digest !== DIG_TWO) begin
      errors++;
      $display("FAIL two_block_digest: got %h, required %h", b_digest, DIG_TWO);
    end
    @(posedge clk); #1;
    checks++;
    if (b_msg !== 32'd1 || b_blk !== 32'd2 || b_dv !== 1'b0) begin
      errors++;
      $display("FAIL two_block_counts: msg=%0d blk=%0d dv=%b, required 1 2 0", b_msg, b_blk, b_dv);
    end
  endtask

  // The buffer still holds the previous block; only correct zero-fill yields SHA-512("").
  task automatic test_last_word0_256();
    int wt, cyc;
    for (int i = 0; i < 16; i++) msg_w[i] = '0;
    msg_w[0] = 64'h8000000000000000;
    pack();
    send_word(1, {256'b0, flat[255:0]}, 1'b1, wt);
    b_valid = 1'b0;
    wait_dv(1, cyc);
    checks++;
    if (b_digest !== DIG_EMPTY || b_blk !== 32'd3) begin
      errors++;
      $display("FAIL zero_fill: digest=%h blk=%0d, required %h 3", b_digest, b_blk, DIG_EMPTY);
    end
    @(posedge clk); #1;
    checks++;
    if (b_msg !== 32'd2) begin
      errors++;
      $display("FAIL zero_fill_msg: msg=%0d, required 2", b_msg);
    end
  endtask

  task automatic test_digest_stall();
    int wt, cyc, bad;
    a_dr = 1'b0;
    load_abc();
    send_word(0, flat[511:0], 1'b0, wt);
    send_word(0, flat[1023:512], 1'b1, wt);
    a_valid = 1'b0;
    wait_dv(0, cyc);
    send_word(0, flat[511:0], 1'b0, wt);
    send_word(0, flat[1023:512], 1'b1, wt);
    a_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_digest !== DIG_ABC || a_dv !== 1'b1 || a_ready !== 1'b0 || a_busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d cycles lost digest/valid or had in_ready=1, required 0", bad);
    end
    a_dr = 1'b1;
    @(posedge clk); #1;
    a_dr = 1'b0;
    checks++;
    if (a_dv !== 1'b0 || a_msg !== 32'd2) begin
      errors++;
      $display("FAIL stall_handshake: dv=%b msg=%0d, required 0 2", a_dv, a_msg);
    end
    wait_dv(0, cyc);
    checks++;
    if (a_digest !== DIG_ABC) begin
      errors++;
      $display("FAIL stall_second_digest: got %h, required %h", a_digest, DIG_ABC);
    end
    a_dr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_msg !== 32'd3 || a_blk !== 32'd3) begin
      errors++;
      $display("FAIL stall_counts: msg=%0d blk=%0d, required 3 3", a_msg, a_blk);
    end
  endtask

  task automatic test_reset_mid_compute();
    int wt, cyc;
    a_dr = 1'b1;
    load_abc();
    send_word(0, flat[511:0], 1'b0, wt);
    send_word(0, flat[1023:512], 1'b1, wt);
    a_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b, required 1", a_busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b1 || a_dv !== 1'b0 || a_blk !== 0 || a_msg !== 0 || a_digest !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b ready=%b dv=%b blk=%0d msg=%0d, required 0 1 0 0 0 with zero digest", a_busy, a_ready, a_dv, a_blk, a_msg);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send_word(0, flat[511:0], 1'b0, wt);
    send_word(0, flat[1023:512], 1'b1, wt);
    a_valid = 1'b0;
    wait_dv(0, cyc);
    checks++;
    if (a_digest !== DIG_ABC) begin
      errors++;
      $display("FAIL mid_digest: got %h, required %h", a_digest, DIG_ABC);
    end
    @(posedge clk); #1;
    checks++;
    if (a_msg !== 32'd1 || a_blk !== 32'd1) begin
      errors++;
      $display("FAIL mid_counts: msg=%0d blk=%0d, required 1 1", a_msg, a_blk);
    end
  endtask

  task automatic test_back_to_back();
    int waits [3][2];
    int cyc;
    pulse_reset();
    a_dr = 1'b1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 16; i++) msg_w[i] = {32'(j + 1), 32'(i * 16'h1111)};
      pack();
      for (int k = 0; k < 2; k++) send_word(0, flat[k*512 +: 512], (j == 2) && (k == 1), waits[j][k]);
    end
    a_valid = 1'b0;
    checks++;
    if (waits[0][0] != 0 || waits[0][1] != 0 || waits[1][0] != 1 || waits[1][1] != 0) begin
      errors++;
      $display("FAIL b2b_refused: waits %0d %0d %0d %0d, required 0 0 1 0", waits[0][0], waits[0][1], waits[1][0], waits[1][1]);
    end
    wait_dv(0, cyc);
    checks++;
    if (a_blk !== 32'd3) begin
      errors++;
      $display("FAIL b2b_blk_count: got %0d, required 3", a_blk);
    end
    @(posedge clk); #1;
    checks++;
    if (a_msg !== 32'd1 || a_dv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_msg_count: msg=%0d dv=%b, required 1 0", a_msg, a_dv);
    end
  endtask

  initial begin
    test_reset();
    test_abc_512();
    test_two_block_256();
    test_last_word0_256();
    test_digest_stall();
    test_reset_mid_compute();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
